load_rsp_tracker: RTL and testbench

Tracks outstanding data-cache load requests between the load unit and the write-through dcache read port. Allocates a buffer ID per issued load and holds its metadata: trans_id, byte offset, size and signedness. Accepts out-of-order cache responses, then aligns and sign-extends the returned data and emits a registered writeback to the scoreboard. Entries can be flushed; responses for flushed entries are dropped.

---
 rtl/load_rsp_tracker_if.sv | 44 ++++
 rtl/load_rsp_tracker.sv | 133 +++++++++++++
 tb/tb_load_rsp_tracker.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_rsp_tracker_if.sv
// Load-unit / dcache-response / writeback bundle for the load response tracker.
// Latency: none, wires only.
// Backpressure: alloc uses valid/ready; responses and writebacks are never stalled.
interface load_rsp_tracker_if #(
  parameter int NR_ENTRIES = 2,
  parameter int XLEN       = 32,
  parameter int DATA_W     = 64,
  parameter int TRANS_ID_W = 2
);
  localparam int ID_W = $clog2(NR_ENTRIES);

  logic                  alloc_valid_i;
  logic                  alloc_ready_o;
  logic [TRANS_ID_W-1:0] alloc_trans_id_i;
  logic [2:0]            alloc_offset_i;
  logic [1:0]            alloc_size_i;
  logic                  alloc_signed_i;
  logic [ID_W-1:0]       alloc_id_o;
  logic                  rsp_valid_i;
  logic [ID_W-1:0]       rsp_id_i;
  logic [DATA_W-1:0]     rsp_data_i;
  logic                  flush_i;
  logic                  wb_valid_o;
  logic [TRANS_ID_W-1:0] wb_trans_id_o;
  logic [XLEN-1:0]       wb_result_o;
  logic                  rsp_err_o;
  logic                  empty_o;

  // Load unit / cache / scoreboard side
  modport master (
    output alloc_valid_i, alloc_trans_id_i, alloc_offset_i, alloc_size_i, alloc_signed_i,
    output rsp_valid_i, rsp_id_i, rsp_data_i, flush_i,
    input  alloc_ready_o, alloc_id_o, wb_valid_o, wb_trans_id_o, wb_result_o,
    input  rsp_err_o, empty_o
  );

  // Tracker side
  modport slave (
    input  alloc_valid_i, alloc_trans_id_i, alloc_offset_i, alloc_size_i, alloc_signed_i,
    input  rsp_valid_i, rsp_id_i, rsp_data_i, flush_i,
    output alloc_ready_o, alloc_id_o, wb_valid_o, wb_trans_id_o, wb_result_o,
    output rsp_err_o, empty_o
  );
endinterface

// File: rtl/load_rsp_tracker.sv
// Tracks outstanding dcache loads, formats out-of-order responses into scoreboard writebacks.
// Latency: alloc_id combinational; writeback / rsp_err registered, one cycle after the response.
// Backpressure: alloc_ready_o low when no entry is FREE; responses and writebacks never stall.
module load_rsp_tracker #(
  parameter int NR_ENTRIES = 2,
  parameter int XLEN       = 32,
  parameter int DATA_W     = 64,
  parameter int TRANS_ID_W = 2
) (
  input logic              clk_i,
  input logic              rst_i,
  load_rsp_tracker_if.slave bus
);
  localparam int ID_W = $clog2(NR_ENTRIES);

  typedef enum logic [1:0] {ST_FREE, ST_PENDING, ST_KILLED} state_e;

  typedef struct packed {
    logic [TRANS_ID_W-1:0] trans_id;
    logic [2:0]            offset;
    logic [1:0]            size;
    logic                  sgn;
  } meta_t;

  state_e                state_q [NR_ENTRIES];
  state_e                state_d [NR_ENTRIES];
  meta_t                 meta_q  [NR_ENTRIES];
  meta_t                 meta_d  [NR_ENTRIES];

  logic                  wb_valid_q, wb_valid_d;
  logic [TRANS_ID_W-1:0] wb_trans_id_q, wb_trans_id_d;
  logic [XLEN-1:0]       wb_result_q, wb_result_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  alloc_ready;
  logic [ID_W-1:0]       alloc_id;
  logic                  all_free;
  logic                  alloc_fire;
  state_e                rsp_state;
  meta_t                 rsp_meta;
  logic [DATA_W-1:0]     shifted;
  logic [63:0]           ext;
  logic                  unused_ext;

  // Lowest-index FREE entry wins; descending scan lets the lowest index assign last.
  always_comb begin
    alloc_ready = 1'b0;
    alloc_id    = '0;
    all_free    = 1'b1;
    for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
      if (state_q[i] == ST_FREE) begin
        alloc_ready = 1'b1;
        alloc_id    = ID_W'(i);
      end else begin
        all_free = 1'b0;
      end
    end
  end

  assign alloc_fire = bus.alloc_valid_i && alloc_ready;
  assign rsp_state  = state_q[bus.rsp_id_i];
  assign rsp_meta   = meta_q[bus.rsp_id_i];

  // Entry state/metadata next-state: response frees, flush kills, allocation (unless flushed) claims.
  always_comb begin
    for (int i = 0; i < NR_ENTRIES; i++) begin
      state_d[i] = state_q[i];
      meta_d[i]  = meta_q[i];
      if (bus.rsp_valid_i && (bus.rsp_id_i == ID_W'(i)) && (state_q[i] != ST_FREE)) begin
        state_d[i] = ST_FREE;
      end else if (bus.flush_i && (state_q[i] == ST_PENDING)) begin
        state_d[i] = ST_KILLED;
      end
      if (alloc_fire && !bus.flush_i && (alloc_id == ID_W'(i))) begin
        state_d[i]         = ST_PENDING;
        meta_d[i].trans_id = bus.alloc_trans_id_i;
        meta_d[i].offset   = bus.alloc_offset_i;
        meta_d[i].size     = bus.alloc_size_i;
        meta_d[i].sgn      = bus.alloc_signed_i;
      end
    end
  end

  // Align the response to the load's byte offset, then sign/zero extend from the access size.
  always_comb begin
    shifted = bus.rsp_data_i >> {rsp_meta.offset, 3'b000};
    ext     = shifted;
    case (rsp_meta.size)
      2'd0:    ext = {{56{rsp_meta.sgn & shifted[7]}},  shifted[7:0]};
      2'd1:    ext = {{48{rsp_meta.sgn & shifted[15]}}, shifted[15:0]};
      2'd2:    ext = {{32{rsp_meta.sgn & shifted[31]}}, shifted[31:0]};
      default: ext = shifted;
    endcase
    wb_valid_d    = bus.rsp_valid_i && (rsp_state == ST_PENDING) && !bus.flush_i;
    rsp_err_d     = bus.rsp_valid_i && (rsp_state == ST_FREE);
    wb_trans_id_d = wb_valid_d ? rsp_meta.trans_id : wb_trans_id_q;
    wb_result_d   = wb_valid_d ? ext[XLEN-1:0] : wb_result_q;
  end

  // Upper extension bits are dropped when XLEN is 32.
  assign unused_ext = ^ext;

  // State and output registers; reset returns every entry to FREE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        state_q[i] <= ST_FREE;
        meta_q[i]  <= '0;
      end
      wb_valid_q    <= 1'b0;
      wb_trans_id_q <= '0;
      wb_result_q   <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        state_q[i] <= state_d[i];
        meta_q[i]  <= meta_d[i];
      end
      wb_valid_q    <= wb_valid_d;
      wb_trans_id_q <= wb_trans_id_d;
      wb_result_q   <= wb_result_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign bus.alloc_ready_o = alloc_ready;
  assign bus.alloc_id_o    = alloc_id;
  assign bus.empty_o       = all_free;
  assign bus.wb_valid_o    = wb_valid_q;
  assign bus.wb_trans_id_o = wb_trans_id_q;
  assign bus.wb_result_o   = wb_result_q;
  assign bus.rsp_err_o     = rsp_err_q;
endmodule

// File: tb/tb_load_rsp_tracker.sv
// Bench for load_rsp_tracker: formatting vector table plus hand sequences for flush/full/error/reset.
// Writebacks are checked by a scoreboard queue filled when the response is driven.
// Combinational outputs are sampled 3 time units after the active edge, registered ones 1 unit after.
module tb_load_rsp_tracker;
  localparam int NR_ENTRIES = 2;
  localparam int XLEN       = 32;
  localparam int DATA_W     = 64;
  localparam int TRANS_ID_W = 2;

  typedef struct packed {
    logic [1:0]  tid;
    logic [31:0] res;
  } wb_t;

  typedef struct {
    logic [2:0]  off;
    logic [1:0]  size;
    logic        sgn;
    logic [63:0] data;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  wb_t  sb_q[$];

  load_rsp_tracker_if #(.NR_ENTRIES(NR_ENTRIES), .XLEN(XLEN), .DATA_W(DATA_W),
                        .TRANS_ID_W(TRANS_ID_W)) ifc ();

  load_rsp_tracker #(.NR_ENTRIES(NR_ENTRIES), .XLEN(XLEN), .DATA_W(DATA_W),
                     .TRANS_ID_W(TRANS_ID_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    ifc.alloc_valid_i    = 1'b0;
    ifc.alloc_trans_id_i = '0;
    ifc.alloc_offset_i   = '0;
    ifc.alloc_size_i     = '0;
    ifc.alloc_signed_i   = 1'b0;
    ifc.rsp_valid_i      = 1'b0;
    ifc.rsp_id_i         = '0;
    ifc.rsp_data_i       = '0;
    ifc.flush_i          = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [1:0] tid, input logic [2:0] off, input logic [1:0] sz,
                       input logic sg);
    ifc.alloc_valid_i    = 1'b1;
    ifc.alloc_trans_id_i = tid;
    ifc.alloc_offset_i   = off;
    ifc.alloc_size_i     = sz;
    ifc.alloc_signed_i   = sg;
  endtask

  task automatic rsp(input logic id, input logic [63:0] data);
    ifc.rsp_valid_i = 1'b1;
    ifc.rsp_id_i    = id;
    ifc.rsp_data_i  = data;
  endtask

  // Scoreboard: every writeback must match the oldest expectation; none may appear unannounced.
  always @(negedge clk) begin
    if (!rst && ifc.wb_valid_o) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_wb: got trans %0d result 0x%0h, expected no writeback",
                 ifc.wb_trans_id_o, ifc.wb_result_o);
      end else begin
        wb_t e;
        e = sb_q.pop_front();
        check("wb_trans_id", 64'(ifc.wb_trans_id_o), 64'(e.tid));
        check("wb_result", 64'(ifc.wb_result_o), 64'(e.res));
      end
    end
  end

  vec_t vecs[10];
  localparam logic [63:0] D1 = 64'h8877665544332211;
  localparam logic [63:0] D2 = 64'h00000000000080F0;

  initial begin
    vecs[0] = '{3'd4, 2'd2, 1'b1, D1, 32'h88776655};
    vecs[1] = '{3'd7, 2'd0, 1'b0, D1, 32'h00000088};
    vecs[2] = '{3'd7, 2'd0, 1'b1, D1, 32'hFFFFFF88};
    vecs[3] = '{3'd0, 2'd3, 1'b1, D1, 32'h44332211};
    vecs[4] = '{3'd2, 2'd1, 1'b1, D1, 32'h00004433};
    vecs[5] = '{3'd6, 2'd1, 1'b1, D1, 32'hFFFF8877};
    vecs[6] = '{3'd4, 2'd2, 1'b0, D1, 32'h88776655};
    vecs[7] = '{3'd1, 2'd0, 1'b1, D1, 32'h00000022};
    vecs[8] = '{3'd1, 2'd1, 1'b0, D2, 32'h00000080};
    vecs[9] = '{3'd0, 2'd0, 1'b0, D2, 32'h000000F0};

    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_alloc_ready", 64'(ifc.alloc_ready_o), 64'd1);
    check("rst_empty", 64'(ifc.empty_o), 64'd1);
    check("rst_wb_valid", 64'(ifc.wb_valid_o), 64'd0);
    check("rst_wb_trans_id", 64'(ifc.wb_trans_id_o), 64'd0);
    check("rst_wb_result", 64'(ifc.wb_result_o), 64'd0);
    check("rst_rsp_err", 64'(ifc.rsp_err_o), 64'd0);

    // Two allocations, responses out of order
    @(posedge clk); #1;
    alloc(2'd1, 3'd0, 2'd1, 1'b0);
    #2 check("alloc0_ready", 64'(ifc.alloc_ready_o), 64'd1);
    check("alloc0_id", 64'(ifc.alloc_id_o), 64'd0);
    cyc();
    alloc(2'd2, 3'd0, 2'd0, 1'b1);
    #2 check("alloc1_id", 64'(ifc.alloc_id_o), 64'd1);
    cyc();
    idle();
    check("full_ready", 64'(ifc.alloc_ready_o), 64'd0);
    check("full_empty", 64'(ifc.empty_o), 64'd0);
    rsp(1'b1, D2);
    sb_q.push_back('{2'd2, 32'hFFFFFFF0});
    cyc();
    idle();
    rsp(1'b0, D2);
    sb_q.push_back('{2'd1, 32'h000080F0});
    cyc();
    idle();
    check("ooo_empty", 64'(ifc.empty_o), 64'd1);
    cyc();

    // Formatting table
    for (int i = 0; i < 10; i++) begin
      alloc(2'(i), vecs[i].off, vecs[i].size, vecs[i].sgn);
      #2 check("vec_alloc_id", 64'(ifc.alloc_id_o), 64'd0);
      cyc();
      idle();
      rsp(1'b0, vecs[i].data);
      sb_q.push_back('{2'(i), vecs[i].exp});
      cyc();
      idle();
    end
    cyc();

    // Flush with two pending entries: responses dropped
    alloc(2'd1, 3'd0, 2'd2, 1'b0);
    cyc();
    alloc(2'd2, 3'd0, 2'd2, 1'b0);
    cyc();
    idle();
    ifc.flush_i = 1'b1;
    cyc();
    idle();
    rsp(1'b0, D1);
    cyc();
    idle();
    check("flush_half_empty", 64'(ifc.empty_o), 64'd0);
    check("killed_rsp_err", 64'(ifc.rsp_err_o), 64'd0);
    rsp(1'b1, D1);
    cyc();
    idle();
    check("flush_empty", 64'(ifc.empty_o), 64'd1);
    check("flush_ready", 64'(ifc.alloc_ready_o), 64'd1);
    cyc();

    // Response to FREE id: one-cycle error pulse
    rsp(1'b1, D1);
    cyc();
    idle();
    check("err_pulse", 64'(ifc.rsp_err_o), 64'd1);
    cyc();
    check("err_pulse_end", 64'(ifc.rsp_err_o), 64'd0);

    // Full buffer: response in the same cycle does not unblock allocation
    alloc(2'd3, 3'd2, 2'd1, 1'b0);
    cyc();
    alloc(2'd0, 3'd0, 2'd3, 1'b1);
    cyc();
    alloc(2'd1, 3'd0, 2'd2, 1'b0);
    rsp(1'b0, D1);
    sb_q.push_back('{2'd3, 32'h00004433});
    #2 check("full_rsp_ready", 64'(ifc.alloc_ready_o), 64'd0);
    cyc();
    ifc.rsp_valid_i = 1'b0;
    #2 check("retry_ready", 64'(ifc.alloc_ready_o), 64'd1);
    check("retry_id", 64'(ifc.alloc_id_o), 64'd0);
    cyc();
    idle();
    rsp(1'b1, D1);
    sb_q.push_back('{2'd0, 32'h44332211});
    cyc();
    idle();
    rsp(1'b0, D1);
    sb_q.push_back('{2'd1, 32'h44332211});
    cyc();
    idle();
    check("retry_empty", 64'(ifc.empty_o), 64'd1);

    // Simultaneous alloc and response on different entries
    alloc(2'd1, 3'd7, 2'd0, 1'b1);
    cyc();
    alloc(2'd2, 3'd4, 2'd2, 1'b1);
    rsp(1'b0, D1);
    sb_q.push_back('{2'd1, 32'hFFFFFF88});
    #2 check("simul_id", 64'(ifc.alloc_id_o), 64'd1);
    cyc();
    idle();
    rsp(1'b1, D1);
    sb_q.push_back('{2'd2, 32'h88776655});
    // Flush in the cycle the writeback is emitted: writeback survives
    cyc();
    idle();
    ifc.flush_i = 1'b1;
    cyc();
    idle();

    // Flush with same-cycle response and allocation: no writeback, allocation dropped
    alloc(2'd2, 3'd0, 2'd0, 1'b0);
    cyc();
    alloc(2'd3, 3'd0, 2'd0, 1'b0);
    rsp(1'b0, D1);
    ifc.flush_i = 1'b1;
    #2 check("flush_alloc_id", 64'(ifc.alloc_id_o), 64'd1);
    cyc();
    idle();
    check("flush_alloc_empty", 64'(ifc.empty_o), 64'd1);
    cyc();

    // Mid-operation reset clears state immediately; late response is an error
    alloc(2'd1, 3'd0, 2'd0, 1'b0);
    cyc();
    idle();
    check("pre_rst_empty", 64'(ifc.empty_o), 64'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_empty", 64'(ifc.empty_o), 64'd1);
    check("mid_rst_ready", 64'(ifc.alloc_ready_o), 64'd1);
    rst = 1'b0;
    cyc();
    rsp(1'b0, D1);
    cyc();
    idle();
    check("post_rst_err", 64'(ifc.rsp_err_o), 64'd1);

    repeat (3) cyc();
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
